// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared UART definitions used by the transmitter, the receiver and the
//   common baud timer:
//     - config field widths (delay frames, data bits)
//     - parity encodings (none / odd / even; 3 behaves as none)
//     - stop-bit encodings (0/1 one, 2 two, 3 one-and-a-half)
//     - transmitter FSM state type
//     - small helpers for decoding the runtime config bus
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    // Config bus field widths
    localparam int UART_CONFIG_WIDTH_DELAYFRAMES = 16;
    localparam int UART_CONFIG_WIDTH_DATABITS    = 8;

    // Parity encodings on UART_CONFIG_PARITY
    localparam logic [1:0] UART_PARITY_NONE = 2'd0;
    localparam logic [1:0] UART_PARITY_ODD  = 2'd1;
    localparam logic [1:0] UART_PARITY_EVEN = 2'd2;

    // Stop-bit encodings on UART_CONFIG_STOPBITS (0 also means one stop bit)
    localparam logic [1:0] UART_STOPBITS_1   = 2'd1;
    localparam logic [1:0] UART_STOPBITS_2   = 2'd2;
    localparam logic [1:0] UART_STOPBITS_1_5 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Only odd and even generate a parity bit; encoding 3 is treated as none.
    function automatic logic parity_enabled(input logic [1:0] parity);
        return (parity == UART_PARITY_ODD) || (parity == UART_PARITY_EVEN);
    endfunction

    // A request of 0 bits, or more bits than the datapath holds, sends a
    // full-width word instead.
    function automatic logic [4:0] clamp_databits(input logic [4:0] req,
                                                  input int         max_bits);
        int max_v;
        max_v = max_bits;
        if ((req == 5'd0) || (int'(req) > max_v)) begin
            return max_v[4:0];
        end
        return req;
    endfunction

    // True when the stop field selects a single full stop bit.
    function automatic logic stop_is_single(input logic [1:0] stopbits);
        return (stopbits != UART_STOPBITS_2) && (stopbits != UART_STOPBITS_1_5);
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// -----------------------------------------------------------------------------
// uart_baud_timer
//   Bit-period timer. A load starts a period of load_val clocks; tick is high
//   on the last clock of that period. almost is high on the clock before the
//   last one, so a registered flag can be set to line up with tick.
//   load_val must be at least 1. When not reloaded the counter rests at 0 with
//   tick held high; users ignore tick while idle.
//
//   Ports:
//     clk       system clock
//     rst       asynchronous active-high reset
//     load      start a new period this clock
//     load_val  period length in clocks (>= 1)
//     tick      last clock of the current period
//     almost    second-to-last clock of the current period
// -----------------------------------------------------------------------------
module uart_baud_timer #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] load_val,
    output logic                     tick,
    output logic                     almost
);

    logic [COUNTER_WIDTH-1:0] cnt;

    // The counter holds "clocks remaining after this one", so a period of N
    // clocks runs N-1 down to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - COUNTER_WIDTH'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - COUNTER_WIDTH'(1);
        end
    end

    assign tick   = (cnt == '0);
    assign almost = (cnt == COUNTER_WIDTH'(1));

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Configurable UART transmitter. One word per frame: start bit, data bits
//   LSB first, optional parity, then 1, 1.5 or 2 stop bits. The data word and
//   the whole config bus are captured when a frame is accepted, so later
//   changes only affect the next frame.
//
//   Handshake: a word is accepted on a rising edge where uart_tx_start and
//   uart_tx_ready are both high. Ready is high only while idle; a start seen
//   while busy is dropped, never queued. Holding start high across the end of
//   a frame sends the next word after exactly one idle-high clock.
//
//   Ports:
//     clk                       system clock
//     rst                       asynchronous active-high reset
//     datain                    word to send (low DATABITS bits used)
//     uart_tx_start             send request
//     uart_tx_ready             idle and able to accept (registered)
//     uart_tx_done              1-clk pulse on the last clock of the frame
//     uart_txpin                serial line, idle high (registered)
//     UART_CONFIG_DELAY_FRAMES  clocks per bit (values below 2 act as 2)
//     UART_CONFIG_DATABITS      data bits per frame (0 or too large = DATA_WIDTH)
//     UART_CONFIG_PARITY        0 none, 1 odd, 2 even, 3 none
//     UART_CONFIG_STOPBITS      0/1 one, 2 two, 3 one-and-a-half
//     state_dbg                 current FSM state (tx_state_t encoding)
// -----------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int COUNTER_WIDTH = UART_CONFIG_WIDTH_DELAYFRAMES,
    parameter int DATA_WIDTH    = UART_CONFIG_WIDTH_DATABITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    datain,
    input  logic                     uart_tx_start,
    output logic                     uart_tx_ready,
    output logic                     uart_tx_done,
    output logic                     uart_txpin,
    input  logic [COUNTER_WIDTH-1:0] UART_CONFIG_DELAY_FRAMES,
    input  logic [4:0]               UART_CONFIG_DATABITS,
    input  logic [1:0]               UART_CONFIG_PARITY,
    input  logic [1:0]               UART_CONFIG_STOPBITS,
    output logic [2:0]               state_dbg
);

    tx_state_t                state;

    // Frame shadow registers, loaded on accept
    logic [DATA_WIDTH-1:0]    shreg;
    logic [4:0]               nbits_r;
    logic [4:0]               bit_idx;
    logic                     par_en_r;
    logic                     par_acc;
    logic                     stop_one_r;
    logic                     stop_half_r;
    logic                     stop_second;
    logic [COUNTER_WIDTH-1:0] delay_r;

    // Timer interface
    logic                     tmr_load;
    logic [COUNTER_WIDTH-1:0] tmr_val;
    logic                     tick;
    logic                     almost;

    // Decode
    logic                     accept;
    logic                     last_data;
    logic                     final_seg;
    logic                     enter_final;
    logic                     done_set;
    logic [COUNTER_WIDTH-1:0] eff_delay;

    assign state_dbg = state;

    uart_baud_timer #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_baud_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick),
        .almost   (almost)
    );

    // A bit period shorter than 2 clocks would leave no room for the
    // half stop bit, so it is raised to 2.
    assign eff_delay = (UART_CONFIG_DELAY_FRAMES < COUNTER_WIDTH'(2)) ?
                       COUNTER_WIDTH'(2) : UART_CONFIG_DELAY_FRAMES;

    // Timer reload and done-pulse scheduling.
    // The stop time is split into two segments (full bit, then a full or half
    // bit) so the counter never needs to hold twice the bit period.
    // done is registered, so it is raised one clock ahead of the final tick;
    // a final segment only 1 clock long raises it as the segment is loaded.
    always_comb begin
        accept      = (state == ST_IDLE) && uart_tx_start && uart_tx_ready;
        last_data   = (bit_idx == (nbits_r - 5'd1));
        final_seg   = stop_one_r || stop_second;
        tmr_load    = 1'b0;
        tmr_val     = delay_r;
        enter_final = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = eff_delay;
                end
            end
            ST_START: begin
                tmr_load = tick;
            end
            ST_DATA: begin
                tmr_load    = tick;
                enter_final = tick && last_data && !par_en_r && stop_one_r;
            end
            ST_PARITY: begin
                tmr_load    = tick;
                enter_final = tick && stop_one_r;
            end
            ST_STOP: begin
                if (tick && !final_seg) begin
                    tmr_load    = 1'b1;
                    enter_final = 1'b1;
                    if (stop_half_r) begin
                        tmr_val = delay_r >> 1;
                    end
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
        done_set = (enter_final && (tmr_val == COUNTER_WIDTH'(1))) ||
                   ((state == ST_STOP) && final_seg && !tick && almost);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            uart_txpin    <= 1'b1;
            uart_tx_ready <= 1'b1;
            uart_tx_done  <= 1'b0;
            shreg         <= '0;
            nbits_r       <= 5'd0;
            bit_idx       <= 5'd0;
            par_en_r      <= 1'b0;
            par_acc       <= 1'b0;
            stop_one_r    <= 1'b1;
            stop_half_r   <= 1'b0;
            stop_second   <= 1'b0;
            delay_r       <= '0;
        end else begin
            uart_tx_done <= done_set;
            case (state)
                ST_IDLE: begin
                    uart_txpin <= 1'b1;
                    if (accept) begin
                        shreg         <= datain;
                        nbits_r       <= clamp_databits(UART_CONFIG_DATABITS, DATA_WIDTH);
                        par_en_r      <= parity_enabled(UART_CONFIG_PARITY);
                        // Seeding with 1 for odd parity makes the running XOR
                        // come out as the odd parity bit directly.
                        par_acc       <= (UART_CONFIG_PARITY == UART_PARITY_ODD);
                        stop_one_r    <= stop_is_single(UART_CONFIG_STOPBITS);
                        stop_half_r   <= (UART_CONFIG_STOPBITS == UART_STOPBITS_1_5);
                        stop_second   <= 1'b0;
                        delay_r       <= eff_delay;
                        bit_idx       <= 5'd0;
                        uart_txpin    <= 1'b0;
                        uart_tx_ready <= 1'b0;
                        state         <= ST_START;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        uart_txpin <= shreg[0];
                        par_acc    <= par_acc ^ shreg[0];
                        shreg      <= shreg >> 1;
                        bit_idx    <= 5'd0;
                        state      <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (last_data) begin
                            if (par_en_r) begin
                                uart_txpin <= par_acc;
                                state      <= ST_PARITY;
                            end else begin
                                uart_txpin  <= 1'b1;
                                stop_second <= 1'b0;
                                state       <= ST_STOP;
                            end
                        end else begin
                            uart_txpin <= shreg[0];
                            par_acc    <= par_acc ^ shreg[0];
                            shreg      <= shreg >> 1;
                            bit_idx    <= bit_idx + 5'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        uart_txpin  <= 1'b1;
                        stop_second <= 1'b0;
                        state       <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (final_seg) begin
                            uart_tx_ready <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            stop_second <= 1'b1;
                        end
                    end
                end

                default: begin
                    uart_txpin    <= 1'b1;
                    uart_tx_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
